// File: rtl/l2_mem_ctrl.sv
// L2 miss controller: an optional dirty-victim writeback, then a block fill,
// then a one-cycle fill response. One outstanding miss at a time.
module l2_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [ADDR_WIDTH-1:0]                 req_addr,
  input  logic                                  req_wb,
  input  logic [ADDR_WIDTH-1:0]                 req_wb_addr,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] req_wb_data,
  output logic                                  resp_valid,
  output logic [ADDR_WIDTH-1:0]                 resp_addr,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_in,
  output logic                                  mem_read,
  output logic                                  mem_write,
  input  logic                                  mem_ready,
  output logic [15:0]                           fill_count,
  output logic [15:0]                           wb_count
);

  localparam int OFS = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 0;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WB   = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]                            state;
  logic [ADDR_WIDTH-1:0]                 fill_addr;
  logic [ADDR_WIDTH-1:0]                 victim_addr;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] victim_data;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Control state; mem_ready only advances WB and FILL, so stray pulses elsewhere are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_addr  <= '0;
      resp_data  <= '0;
      fill_count <= '0;
      wb_count   <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) state <= req_wb ? WB : FILL;
        WB: if (mem_ready) begin
          state    <= FILL;
          wb_count <= sat_inc(wb_count);
        end
        FILL: if (mem_ready) begin
          state      <= RESP;
          resp_addr  <= fill_addr;
          resp_data  <= mem_data_in;
          fill_count <= sat_inc(fill_count);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture; only meaningful while a miss is in flight, so no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      fill_addr   <= req_addr & ALIGN_MASK;
      victim_addr <= req_wb_addr & ALIGN_MASK;
      victim_data <= req_wb_data;
    end
  end

  assign req_ready  = (state == IDLE);
  assign mem_write  = (state == WB);
  assign mem_read   = (state == FILL);
  assign resp_valid = (state == RESP);

  always_comb begin
    mem_addr     = '0;
    mem_data_out = '0;
    case (state)
      WB: begin
        mem_addr     = victim_addr;
        mem_data_out = victim_data;
      end
      FILL:    mem_addr = fill_addr;
      default: ;
    endcase
  end

endmodule
